// File: rtl/rank_filter_pipe.sv
// Pipelined rank-order filter: accepts one WIN_SIZE-pixel window per cycle and
// returns the pixel of the requested rank (min..max), with valid/ready back-pressure.
module rank_filter_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 9,
  parameter int RANK_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIN_SIZE*DATA_WIDTH-1:0] in_window,
  input  logic [RANK_WIDTH-1:0]          in_rank,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_pixel
);

  localparam logic [RANK_WIDTH-1:0] RANK_MAX = RANK_WIDTH'(WIN_SIZE - 1);

  typedef logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] win_t;
  typedef logic [WIN_SIZE-1:0][RANK_WIDTH-1:0] pos_vec_t;

  logic                  adv;

  logic                  s0_valid;
  win_t                  s0_win;
  logic [RANK_WIDTH-1:0] s0_rank;

  logic                  s1_valid;
  win_t                  s1_win;
  pos_vec_t              s1_pos;
  logic [RANK_WIDTH-1:0] s1_rank;

  pos_vec_t              pos_c;
  logic [RANK_WIDTH-1:0] rank_eff_c;
  logic [DATA_WIDTH-1:0] sel_c;

  // The whole pipe moves as one; it only freezes when the output is held.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Ties are broken by pixel index, so the positions form a permutation of 0..WIN_SIZE-1.
  always_comb begin
    pos_c = '0;
    for (int unsigned i = 0; i < WIN_SIZE; i++) begin
      for (int unsigned j = 0; j < WIN_SIZE; j++) begin
        if ((s0_win[j] < s0_win[i]) || ((j < i) && (s0_win[j] == s0_win[i])))
          pos_c[i] = pos_c[i] + 1'b1;
      end
    end
  end

  assign rank_eff_c = (s0_rank > RANK_MAX) ? RANK_MAX : s0_rank;

  // Exactly one position matches, so an AND-OR mux is sufficient.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < WIN_SIZE; i++)
      sel_c = sel_c | ({DATA_WIDTH{s1_pos[i] == s1_rank}} & s1_win[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_win   <= '0;
      s0_rank  <= '0;
    end else if (adv) begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_win  <= in_window;
        s0_rank <= in_rank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_win   <= '0;
      s1_pos   <= '0;
      s1_rank  <= '0;
    end else if (adv) begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_win  <= s0_win;
        s1_pos  <= pos_c;
        s1_rank <= rank_eff_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid)
        out_pixel <= sel_c;
    end
  end

endmodule

// File: tb/tb_rank_filter_pipe.sv
// Self-checking bench for rank_filter_pipe: table vectors, directed latency/stall/reset
// sequences, and randomized traffic scored against a sort-based reference model.
module tb_rank_filter_pipe;

  localparam int DW = 8;
  localparam int WS = 9;
  localparam int RW = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [WS*DW-1:0] in_window;
  logic [RW-1:0]   in_rank;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_pixel;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic          prev_stall;
  logic [DW-1:0] prev_pix;

  rank_filter_pipe #(
    .DATA_WIDTH(DW),
    .WIN_SIZE  (WS),
    .RANK_WIDTH(RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_window(in_window),
    .in_rank  (in_rank),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sort the window and index it with the clamped rank.
  function automatic logic [DW-1:0] model(input logic [WS*DW-1:0] w, input logic [RW-1:0] r);
    int q[$];
    int k;
    for (int i = 0; i < WS; i++) q.push_back(int'(w[i*DW +: DW]));
    q.sort();
    k = (int'(r) >= WS) ? WS - 1 : int'(r);
    return DW'(q[k]);
  endfunction

  function automatic logic [WS*DW-1:0] pk(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5,
                                          input int p6, input int p7, input int p8);
    int p[WS];
    logic [WS*DW-1:0] r;
    p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
    r = '0;
    for (int i = 0; i < WS; i++) r[i*DW +: DW] = DW'(p[i]);
    return r;
  endfunction

  // Scoreboard: inputs are driven #1 after posedge, so the negedge sees what the next edge will.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_output", 32'(out_pixel), 32'hFFFF_FFFF);
        else check("sb_pixel", 32'(out_pixel), 32'(exp_q.pop_front()));
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) check("stall_hold", 32'(out_pixel), 32'(prev_pix));
        prev_stall = 1'b1;
        prev_pix   = out_pixel;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_window, in_rank));
    end
  end

  typedef struct {
    logic [WS*DW-1:0] win;
    logic [RW-1:0]    rank;
    logic [DW-1:0]    exp;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latency_seq(input string tag);
    in_valid  = 1'b1;
    in_window = pk(3, 9, 1, 7, 5, 2, 8, 6, 4);
    in_rank   = RW'(4);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat_k0"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_lat_k1"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_lat_k2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat_k2_pixel"}, 32'(out_pixel), 32'd5);
    step();
    check({tag, "_lat_bubble"}, 32'(out_valid), 32'd0);
    check({tag, "_lat_keep_pixel"}, 32'(out_pixel), 32'd5);
  endtask

  initial begin
    logic [WS*DW-1:0] base;
    int pix;
    bit dup;

    base = pk(3, 9, 1, 7, 5, 2, 8, 6, 4);
    tbl[0] = '{base, RW'(4), DW'(5)};
    tbl[1] = '{base, RW'(0), DW'(1)};
    tbl[2] = '{base, RW'(8), DW'(9)};
    tbl[3] = '{base, RW'(12), DW'(9)};
    tbl[4] = '{pk(7, 7, 7, 7, 7, 7, 7, 7, 7), RW'(4), DW'(7)};
    tbl[5] = '{pk(0, 255, 0, 255, 0, 255, 0, 255, 0), RW'(4), DW'(0)};
    tbl[6] = '{pk(0, 255, 0, 255, 0, 255, 0, 255, 0), RW'(5), DW'(255)};
    tbl[7] = '{pk(200, 10, 10, 90, 255, 0, 90, 31, 10), RW'(31), DW'(255)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_window = '0; in_rank = '0;
    repeat (3) step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_pixel", 32'(out_pixel), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    latency_seq("first");

    // Table vectors back-to-back; result for entry c-2 is visible after edge c.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_window = tbl[c].win; in_rank = tbl[c].rank;
      end else begin
        in_valid = 1'b0;
      end
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      step();
      if (c >= 2) begin
        check($sformatf("tbl%0d_valid", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("tbl%0d_pixel", c - 2), 32'(out_pixel), 32'(tbl[c-2].exp));
      end
    end
    step();
    check("tbl_drained", 32'(out_valid), 32'd0);

    // Fill the pipe while the output is blocked, then release.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_window = base; in_rank = RW'(c * 4);
      step();
    end
    in_rank = RW'(2);
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_pixel", 32'(out_pixel), 32'd1);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_rel1_valid", 32'(out_valid), 32'd1);
    check("bp_rel1_pixel", 32'(out_pixel), 32'd5);
    step();
    check("bp_rel2_valid", 32'(out_valid), 32'd1);
    check("bp_rel2_pixel", 32'(out_pixel), 32'd9);
    step();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset with windows in flight and a result on the output.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_window = base; in_rank = RW'(c * 4);
      step();
    end
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    check("rst_pre_pixel", 32'(out_pixel), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_pixel", 32'(out_pixel), 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    latency_seq("post_rst");

    // Randomized traffic scored by the reference model.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      dup = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < WS; i++) begin
        pix = dup ? int'($urandom_range(0, 3)) * 85 : int'($urandom_range(0, 255));
        in_window[i*DW +: DW] = DW'(pix);
      end
      in_rank = RW'($urandom_range(0, 31));
      step();
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
